shift_add_multiplier: RTL

Iterative radix-2 shift-and-add unsigned multiplier that forms the full double-width product of two `width`-bit operands. It sits directly upstream of the Barrett reduction stage: its `ab` output and `done` flag drive that stage's `a` input and `enable`, forming the modular-multiply path of the MSM datapath. It trades latency for area: one adder of `2*width` bits, one multiplier bit consumed per cycle.

---
 rtl/msm_pkg.sv | 8 +
 rtl/shift_add_multiplier.sv | 101 ++++++++++
 2 files changed

// File: rtl/msm_pkg.sv
// msm_pkg: shared types and helpers for the MSM datapath.
// Holds the multiplier state encoding and the iteration-counter width helper.
package msm_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
    function automatic int count_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative radix-2 shift-and-add unsigned multiplier.
// Ports:
//   clk, reset (sync, active-high), enable (level request, held until done seen)
//   a, b   [width-1:0]   operands, sampled on the start edge
//   ab     [2*width-1:0] product register, held until the next completion
//   done   result valid, held until enable falls
//   busy   high while iterating
// Build option: SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN finishes as soon as the
// remaining multiplier bits are all zero.
module shift_add_multiplier
    import msm_pkg::*;
#(
    parameter int width = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    output logic [2*width-1:0]   ab,
    output logic                 done,
    output logic                 busy
);
    localparam int CW = count_w(width);
    mul_state_t state_q, state_d;
    logic [2*width-1:0] mcand_q, mcand_d, acc_q, acc_d, ab_q, ab_d, acc_next;
    logic [width-1:0] mplier_q, mplier_d;
    logic [CW-1:0] count_q, count_d;
    logic done_q, done_d, busy_q, busy_d, last;
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        last = (count_q == CW'(width - 1)) || ((mplier_q >> 1) == '0);
`else
        last = count_q == CW'(width - 1);
`endif
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ab_d     = ab_q;
        done_d   = done_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: if (enable) begin
                mcand_d  = {{width{1'b0}}, a};
                mplier_d = b;
                acc_d    = '0;
                count_d  = '0;
                busy_d   = 1'b1;
                state_d  = RUN;
            end
            RUN: if (!enable) begin
                // abort: result register keeps the previous product
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (last) begin
                    ab_d    = acc_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: if (!enable) begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            ab_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ab_q     <= ab_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end
    assign ab   = ab_q;
    assign done = done_q;
    assign busy = busy_q;
endmodule
